// File: rtl/pitch_event_debounce.sv
// -----------------------------------------------------------------------------
// pitch_event_debounce
//
// Debounces the once-per-frame peak-bin output of the FFT pitch detector into
// clean command events for the robot control logic. Each valid frame is
// classified by bin range as WHISTLE, BEEP or NONE. A run of CONFIRM_FRAMES
// consecutive frames of one class fires a single-cycle event. The event stays
// active until RELEASE_FRAMES non-matching frames arrive, or until the
// pitch_valid timeout. A hold-off lockout of HOLDOFF_CYCLES clocks then
// follows before the block re-arms.
//
// Ports:
//   clk           fft_clk domain clock
//   reset         asynchronous, active-low reset
//   pitch_k       peak bin of the current frame (0 = silence)
//   pitch_valid   one-cycle strobe per FFT frame; pitch_k sampled only when high
//   event_valid   one-cycle pulse, one cycle after the confirming frame strobe
//   event_code    00 none, 01 whistle, 10 beep; held from confirm until IDLE
//   event_active  high while CONFIRMED
//   busy          high in any state other than IDLE
//   whistle_count saturating count of whistle events (PITCH_EVENT_STATS_EN only)
//   beep_count    saturating count of beep events    (PITCH_EVENT_STATS_EN only)
//
// Build option:
//   PITCH_EVENT_STATS_EN  when defined, adds the whistle_count/beep_count
//                         outputs. Event behaviour is identical either way.
// -----------------------------------------------------------------------------
module pitch_event_debounce #(
    parameter int unsigned NSamples       = 256,
    parameter int unsigned LOWER_WHISTLE  = 45,
    parameter int unsigned UPPER_WHISTLE  = 60,
    parameter int unsigned LOWER_BEEP     = 10,
    parameter int unsigned UPPER_BEEP     = 20,
    parameter int unsigned CONFIRM_FRAMES = 4,
    parameter int unsigned RELEASE_FRAMES = 3,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    localparam int unsigned K_W           = $clog2(NSamples)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [K_W-1:0] pitch_k,
    input  logic           pitch_valid,
    output logic           event_valid,
    output logic [1:0]     event_code,
    output logic           event_active,
    output logic           busy
`ifdef PITCH_EVENT_STATS_EN
    ,
    output logic [15:0]    whistle_count,
    output logic [15:0]    beep_count
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CANDIDATE = 2'd1;
    localparam logic [1:0] CONFIRMED = 2'd2;
    localparam logic [1:0] HOLDOFF   = 2'd3;

    localparam logic [1:0] CLASS_NONE    = 2'b00;
    localparam logic [1:0] CLASS_WHISTLE = 2'b01;
    localparam logic [1:0] CLASS_BEEP    = 2'b10;

    // frame_cnt serves both the confirm run and the release run, so it is sized
    // for the larger of the two and saturates there.
    localparam int unsigned FRAME_MAX =
        (CONFIRM_FRAMES > RELEASE_FRAMES) ? CONFIRM_FRAMES : RELEASE_FRAMES;
    localparam int unsigned FRAME_W = $clog2(FRAME_MAX + 1);

    localparam logic [FRAME_W-1:0] CONFIRM_CNT = FRAME_W'(CONFIRM_FRAMES);
    localparam logic [FRAME_W-1:0] RELEASE_CNT = FRAME_W'(RELEASE_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_SAT   = FRAME_W'(FRAME_MAX);
    localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [1:0]         cand_class_q, cand_class_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [31:0]        cyc_cnt_q, cyc_cnt_d;

    logic               event_valid_q, event_valid_d;
    logic [1:0]         event_code_q, event_code_d;
    logic               event_active_q, event_active_d;
    logic               busy_q, busy_d;

    // -------------------------------------------------------------------------
    // Frame classification (combinational, used only with pitch_valid)
    // -------------------------------------------------------------------------
    logic [31:0] k_ext;
    logic [1:0]  frame_class;

    always_comb begin
        // Widen before comparing so an upper bound equal to NSamples still works.
        k_ext = 32'(pitch_k);
        if ((k_ext > 32'(LOWER_WHISTLE)) && (k_ext < 32'(UPPER_WHISTLE))) begin
            frame_class = CLASS_WHISTLE;
        end else if ((k_ext > 32'(LOWER_BEEP)) && (k_ext < 32'(UPPER_BEEP))) begin
            frame_class = CLASS_BEEP;
        end else begin
            frame_class = CLASS_NONE;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating increments and timeout detection
    // -------------------------------------------------------------------------
    logic [FRAME_W-1:0] frame_inc;
    logic [31:0]        cyc_inc;
    logic               timeout;

    always_comb begin
        frame_inc = (frame_cnt_q == FRAME_SAT) ? frame_cnt_q : (frame_cnt_q + FRAME_ONE);
        cyc_inc   = (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : (cyc_cnt_q + 32'd1);
        // A frame arriving in the same cycle takes priority over the timeout.
        timeout   = !pitch_valid && (cyc_cnt_q >= TIMEOUT_LAST);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic fire;

    always_comb begin
        state_d      = state_q;
        cand_class_d = cand_class_q;
        frame_cnt_d  = frame_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        fire         = 1'b0;

        unique case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                cyc_cnt_d   = '0;
                if (pitch_valid && (frame_class != CLASS_NONE)) begin
                    cand_class_d = frame_class;
                    if (CONFIRM_FRAMES == 1) begin
                        state_d = CONFIRMED;
                        fire    = 1'b1;
                    end else begin
                        state_d     = CANDIDATE;
                        frame_cnt_d = FRAME_ONE;
                    end
                end
            end

            CANDIDATE: begin
                if (pitch_valid) begin
                    cyc_cnt_d = '0;
                    if (frame_class == CLASS_NONE) begin
                        state_d     = IDLE;
                        frame_cnt_d = '0;
                    end else if (frame_class == cand_class_q) begin
                        // Compare the incremented count so the confirming frame
                        // itself completes the run.
                        if (frame_inc >= CONFIRM_CNT) begin
                            state_d     = CONFIRMED;
                            frame_cnt_d = '0;
                            fire        = 1'b1;
                        end else begin
                            frame_cnt_d = frame_inc;
                        end
                    end else begin
                        // The other class restarts the run rather than aborting it.
                        cand_class_d = frame_class;
                        frame_cnt_d  = FRAME_ONE;
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    frame_cnt_d = '0;
                    cyc_cnt_d   = '0;
                end else begin
                    cyc_cnt_d = cyc_inc;
                end
            end

            CONFIRMED: begin
                // frame_cnt here counts consecutive non-matching frames.
                if (pitch_valid) begin
                    cyc_cnt_d = '0;
                    if (frame_class == cand_class_q) begin
                        frame_cnt_d = '0;
                    end else if (frame_inc >= RELEASE_CNT) begin
                        state_d     = HOLDOFF;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end else if (timeout) begin
                    state_d     = HOLDOFF;
                    frame_cnt_d = '0;
                    cyc_cnt_d   = '0;
                end else begin
                    cyc_cnt_d = cyc_inc;
                end
            end

            HOLDOFF: begin
                // Frames are ignored; cyc_cnt now measures the lockout.
                if (cyc_cnt_q >= HOLDOFF_LAST) begin
                    state_d      = IDLE;
                    cyc_cnt_d    = '0;
                    frame_cnt_d  = '0;
                    cand_class_d = CLASS_NONE;
                end else begin
                    cyc_cnt_d = cyc_inc;
                end
            end

            default: begin
                state_d      = IDLE;
                cand_class_d = CLASS_NONE;
                frame_cnt_d  = '0;
                cyc_cnt_d    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs, derived from the next state so they line up with it
    // -------------------------------------------------------------------------
    always_comb begin
        event_valid_d  = fire;
        event_active_d = (state_d == CONFIRMED);
        busy_d         = (state_d != IDLE);
        if (fire) begin
            event_code_d = cand_class_d;
        end else if (state_d == IDLE) begin
            event_code_d = CLASS_NONE;
        end else begin
            event_code_d = event_code_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cand_class_q   <= CLASS_NONE;
            frame_cnt_q    <= '0;
            cyc_cnt_q      <= '0;
            event_valid_q  <= 1'b0;
            event_code_q   <= CLASS_NONE;
            event_active_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_class_q   <= cand_class_d;
            frame_cnt_q    <= frame_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            event_valid_q  <= event_valid_d;
            event_code_q   <= event_code_d;
            event_active_q <= event_active_d;
            busy_q         <= busy_d;
        end
    end

    assign event_valid  = event_valid_q;
    assign event_code   = event_code_q;
    assign event_active = event_active_q;
    assign busy         = busy_q;

`ifdef PITCH_EVENT_STATS_EN
    // -------------------------------------------------------------------------
    // Event statistics: counted alongside the event_valid pulse, saturating
    // -------------------------------------------------------------------------
    logic [15:0] whistle_count_q, whistle_count_d;
    logic [15:0] beep_count_q, beep_count_d;

    always_comb begin
        whistle_count_d = whistle_count_q;
        beep_count_d    = beep_count_q;
        if (fire && (event_code_d == CLASS_WHISTLE) && (whistle_count_q != 16'hFFFF)) begin
            whistle_count_d = whistle_count_q + 16'd1;
        end
        if (fire && (event_code_d == CLASS_BEEP) && (beep_count_q != 16'hFFFF)) begin
            beep_count_d = beep_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            whistle_count_q <= '0;
            beep_count_q    <= '0;
        end else begin
            whistle_count_q <= whistle_count_d;
            beep_count_q    <= beep_count_d;
        end
    end

    assign whistle_count = whistle_count_q;
    assign beep_count    = beep_count_q;
`endif

endmodule

// File: tb/tb_pitch_event_debounce.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pitch_event_debounce (default parameters).
// Expected events are queued as the confirming frame is driven; a monitor pops
// them as event_valid pulses and checks code and cycle of arrival.
// -----------------------------------------------------------------------------
module tb_pitch_event_debounce;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_WH   = 2'b01;
    localparam logic [1:0] C_BP   = 2'b10;

    logic       clk;
    logic       reset;
    logic [7:0] pitch_k;
    logic       pitch_valid;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_active;
    logic       busy;
`ifdef PITCH_EVENT_STATS_EN
    logic [15:0] whistle_count;
    logic [15:0] beep_count;
`endif

    pitch_event_debounce dut (
        .clk          (clk),
        .reset        (reset),
        .pitch_k      (pitch_k),
        .pitch_valid  (pitch_valid),
        .event_valid  (event_valid),
        .event_code   (event_code),
        .event_active (event_active),
        .busy         (busy)
`ifdef PITCH_EVENT_STATS_EN
        ,
        .whistle_count(whistle_count),
        .beep_count   (beep_count)
`endif
    );

    typedef struct {
        logic [1:0]  code;
        int unsigned cyc;
    } exp_ev_t;

    exp_ev_t     exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        exp_ev_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && event_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got event code=%b at cycle %0d, required none",
                             event_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (event_code !== e.code || cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL event_match: got code=%b cycle=%0d, required code=%b cycle=%0d",
                                 event_code, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end at #1 after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] k, input logic [1:0] exp_code);
        exp_ev_t e;
        pitch_k     = k;
        pitch_valid = 1'b1;
        @(posedge clk);
        #1;
        pitch_valid = 1'b0;
        if (exp_code != C_NONE) begin
            e.code = exp_code;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            idle(1);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    // Release a confirmed event with three silent frames and sit out the hold-off.
    task automatic finish_event();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'd0, C_NONE);
            idle(7);
        end
        wait_idle(1200);
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        pitch_valid = 1'b0;
        pitch_k     = 8'd0;
        idle(3);
        n_checks++;
        if ({event_valid, event_code, event_active, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {event_valid, event_code, event_active, busy});
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if ({event_valid, event_code, event_active, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_exit: got %b, required 00000",
                     {event_valid, event_code, event_active, busy});
        end
    endtask

    task automatic test_whistle_confirm();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'd50, (i == 3) ? C_WH : C_NONE);
            if (i == 2) begin
                n_checks++;
                if (busy !== 1'b1 || event_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL whistle_candidate: busy=%b active=%b, required 1 0",
                             busy, event_active);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (event_valid !== 1'b1 || event_code !== C_WH || event_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL whistle_confirm: valid=%b code=%b active=%b, required 1 01 1",
                             event_valid, event_code, event_active);
                end
            end
            idle(7);
        end
    endtask

    task automatic test_release_holdoff();
        logic [7:0]  ks[5] = '{8'd0, 8'd15, 8'd50, 8'd0, 8'd0};
        int unsigned t0;
        // A matching frame mid-release resets the non-match run.
        foreach (ks[i]) begin
            send_frame(ks[i], C_NONE);
            idle(7);
        end
        n_checks++;
        if (event_active !== 1'b1 || event_code !== C_WH) begin
            n_fail++;
            $display("FAIL release_rearm: active=%b code=%b, required 1 01",
                     event_active, event_code);
        end
        send_frame(8'd0, C_NONE);
        t0 = cyc;
        n_checks++;
        if (event_active !== 1'b0 || busy !== 1'b1 || event_code !== C_WH) begin
            n_fail++;
            $display("FAIL release_fall: active=%b busy=%b code=%b, required 0 1 01",
                     event_active, busy, event_code);
        end
        for (int i = 0; i < 5; i++) begin
            idle(7);
            send_frame(8'd50, C_NONE);
        end
        while (cyc < t0 + 1023) idle(1);
        n_checks++;
        if (busy !== 1'b1 || event_code !== C_WH) begin
            n_fail++;
            $display("FAIL holdoff_last: busy=%b code=%b, required 1 01", busy, event_code);
        end
        idle(1);
        n_checks++;
        if (busy !== 1'b0 || event_code !== C_NONE || event_active !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff_end: busy=%b code=%b active=%b, required 0 00 0",
                     busy, event_code, event_active);
        end
        idle(5);
    endtask

    task automatic test_restart_beep();
        logic [7:0] ks[7] = '{8'd15, 8'd15, 8'd50, 8'd15, 8'd15, 8'd15, 8'd15};
        foreach (ks[i]) begin
            send_frame(ks[i], (i == 6) ? C_BP : C_NONE);
            if (i == 5) begin
                n_checks++;
                if (busy !== 1'b1 || event_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_pending: busy=%b active=%b, required 1 0",
                             busy, event_active);
                end
            end
            idle(7);
        end
        n_checks++;
        if (event_active !== 1'b1 || event_code !== C_BP) begin
            n_fail++;
            $display("FAIL restart_beep: active=%b code=%b, required 1 10", event_active, event_code);
        end
        finish_event();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send_frame(8'd15, (i == 3) ? C_BP : C_NONE);
        n_checks++;
        if (event_active !== 1'b1 || event_code !== C_BP) begin
            n_fail++;
            $display("FAIL b2b_confirm: active=%b code=%b, required 1 10", event_active, event_code);
        end
        send_frame(8'd0, C_NONE);
        send_frame(8'd0, C_NONE);
        n_checks++;
        if (event_active !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: active=%b, required 1", event_active);
        end
        send_frame(8'd0, C_NONE);
        n_checks++;
        if (event_active !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_release: active=%b busy=%b, required 0 1", event_active, busy);
        end
        wait_idle(1100);
        idle(3);
    endtask

    task automatic test_timeout();
        int unsigned t0;
        send_frame(8'd50, C_NONE);
        idle(7);
        send_frame(8'd50, C_NONE);
        t0 = cyc;
        while (cyc < t0 + 65535) idle(1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_last: busy=%b, required 1", busy);
        end
        idle(1);
        n_checks++;
        if (busy !== 1'b0 || event_code !== C_NONE) begin
            n_fail++;
            $display("FAIL timeout_idle: busy=%b code=%b, required 0 00", busy, event_code);
        end
        idle(3);
        for (int i = 0; i < 4; i++) begin
            send_frame(8'd50, (i == 3) ? C_WH : C_NONE);
            idle(7);
        end
        n_checks++;
        if (event_active !== 1'b1 || event_code !== C_WH) begin
            n_fail++;
            $display("FAIL timeout_rearm: active=%b code=%b, required 1 01",
                     event_active, event_code);
        end
        finish_event();
    endtask

    task automatic test_reset_mid();
        // Mid-CANDIDATE with frame_cnt = 3.
        for (int i = 0; i < 3; i++) begin
            send_frame(8'd50, C_NONE);
            idle(7);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cand_busy: busy=%b, required 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({event_valid, event_code, event_active, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_cand: got %b, required 00000",
                     {event_valid, event_code, event_active, busy});
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'd50, C_NONE);
        idle(7);
        n_checks++;
        if (busy !== 1'b1 || event_active !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_cand: busy=%b active=%b, required 1 0", busy, event_active);
        end
        send_frame(8'd0, C_NONE);
        idle(2);

        // Mid-HOLDOFF.
        for (int i = 0; i < 4; i++) begin
            send_frame(8'd50, (i == 3) ? C_WH : C_NONE);
            idle(7);
        end
        for (int i = 0; i < 3; i++) begin
            send_frame(8'd0, C_NONE);
            idle(7);
        end
        idle(100);
        n_checks++;
        if (busy !== 1'b1 || event_code !== C_WH || event_active !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_holdoff: busy=%b code=%b active=%b, required 1 01 0",
                     busy, event_code, event_active);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({event_valid, event_code, event_active, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_holdoff: got %b, required 00000",
                     {event_valid, event_code, event_active, busy});
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'd50, C_NONE);
        idle(20);
        n_checks++;
        if (busy !== 1'b1 || event_active !== 1'b0 || event_code !== C_NONE) begin
            n_fail++;
            $display("FAIL post_reset_hold: busy=%b active=%b code=%b, required 1 0 00",
                     busy, event_active, event_code);
        end
        send_frame(8'd0, C_NONE);
        idle(2);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b, required 0", busy);
        end
    endtask

`ifdef PITCH_EVENT_STATS_EN
    task automatic test_stats();
        logic [1:0] seq[5] = '{C_WH, C_BP, C_WH, C_BP, C_WH};
        foreach (seq[j]) begin
            for (int i = 0; i < 4; i++) begin
                send_frame((seq[j] == C_WH) ? 8'd50 : 8'd15, (i == 3) ? seq[j] : C_NONE);
                idle(7);
            end
            finish_event();
        end
        n_checks++;
        if (whistle_count !== 16'd3 || beep_count !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_count: whistle=%0d beep=%0d, required 3 2",
                     whistle_count, beep_count);
        end
        force dut.whistle_count_q = 16'hFFFF;
        #1;
        release dut.whistle_count_q;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'd50, (i == 3) ? C_WH : C_NONE);
            idle(7);
        end
        finish_event();
        n_checks++;
        if (whistle_count !== 16'hFFFF || beep_count !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_saturate: whistle=%h beep=%0d, required ffff 2",
                     whistle_count, beep_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_whistle_confirm();
        test_release_holdoff();
        test_restart_beep();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef PITCH_EVENT_STATS_EN
        test_stats();
`endif
        idle(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected events never seen, required 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
